// File: rtl/spi_pkg.sv
// Shared types for the SPI master shift engine.
// Bit order, engine FSM states and the packed CPOL/CPHA mode.
package spi_pkg;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } spi_engine_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clock_generator.sv
// SCLK half-period tick generator with leading/trailing edge flag.
// Count and phase sit at zero while disabled, so each frame restarts.
module spi_clock_generator #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o,
  output logic                 lead_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;

  assign lead_o = ~phase_q;

  // tick every div_i+1 enabled cycles; phase flips on each tick
  always_comb begin
    tick_o  = en_i && (cnt_q == div_i);
    cnt_d   = '0;
    phase_d = 1'b0;
    if (en_i) begin
      cnt_d   = tick_o ? '0 : cnt_q + 1'b1;
      phase_d = phase_q ^ tick_o;
    end
  end

  // counter and phase registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI master shift engine, all CPOL/CPHA modes.
// Optional SPI_LOOPBACK_EN adds loopback_i: RX samples internal MOSI.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 16,
  localparam int LW = $clog2(DATA_WIDTH),
  localparam int EW = LW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [LW-1:0]         length_i,
  input  bit_order_t            bit_order_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback_i,
`endif
  output logic                  spi_sclk_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  spi_engine_state_t     state_q, state_d;
  bit_order_t            ord_q, ord_d, ord_e;
  spi_mode_t             mode_q, mode_d, mode_e;
  logic [DIV_WIDTH-1:0]  div_q, div_d, div_e;
  logic [LW-1:0]         len_q, len_d, len_e;
  logic [LW-1:0]         idx_q, idx_d, idx_e, idx_n, first;
  logic [EW-1:0]         edge_q, edge_d, edge_e;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, tx_e;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, rx_e;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sclk_q, sclk_d, sclk_e;
  logic                  mosi_q, mosi_d;
  logic                  fire, run, gen_en;
  logic                  tick, lead, sample, adv, last, rx_bit;

  // the accepting cycle already runs the first edge when div is 0,
  // so frame state is taken from the inputs while start fires
  always_comb begin
    fire   = (state_q == IDLE) && start_i;
    run    = fire || (state_q == SHIFT);
    gen_en = run || (state_q == HOLD);
    first  = (bit_order_i == MSB_FIRST) ? length_i : '0;
    ord_e  = fire ? bit_order_i : ord_q;
    mode_e = fire ? spi_mode_t'{cpol: cpol_i, cpha: cpha_i} : mode_q;
    div_e  = fire ? clk_div_i : div_q;
    len_e  = fire ? length_i : len_q;
    tx_e   = fire ? data_i : tx_q;
    idx_e  = fire ? first : idx_q;
    edge_e = fire ? '0 : edge_q;
    rx_e   = fire ? '0 : rx_q;
    sclk_e = fire ? cpol_i : sclk_q;
  end

`ifdef SPI_LOOPBACK_EN
  logic lb_q, lb_e;

  assign lb_e   = fire ? loopback_i : lb_q;
  assign rx_bit = lb_e ? tx_e[idx_e] : spi_miso_i;

  // loopback select, held for the whole frame
  always_ff @(posedge clk_i) begin
    if (rst_i) lb_q <= 1'b0;
    else       lb_q <= lb_e;
  end
`else
  assign rx_bit = spi_miso_i;
`endif

  spi_clock_generator #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (gen_en),
    .div_i  (div_e),
    .tick_o (tick),
    .lead_o (lead)
  );

  // FSM next state, SCLK edges, MOSI advance and MISO capture
  always_comb begin
    state_d = state_q;
    ord_d   = ord_e;
    mode_d  = mode_e;
    div_d   = div_e;
    len_d   = len_e;
    tx_d    = tx_e;
    idx_d   = idx_e;
    edge_d  = edge_e;
    rx_d    = rx_e;
    data_d  = data_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    idx_n   = (ord_e == MSB_FIRST) ? idx_e - 1'b1 : idx_e + 1'b1;
    last    = (edge_e == {len_e, 1'b1});
    sample  = run && tick && (lead ^ mode_e.cpha);
    adv     = run && tick && !(lead ^ mode_e.cpha)
              && (mode_e.cpha ? (edge_e != '0) : !last);
    unique case (state_q)
      IDLE: begin
        sclk_d = cpol_i;
        if (start_i) begin
          state_d = SHIFT;
          mosi_d  = data_i[first];
        end
      end
      SHIFT: ;
      HOLD: begin
        if (tick) begin
          state_d = DONE;
          data_d  = rx_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (run && tick) begin
      sclk_d = last ? mode_e.cpol : ~sclk_e;
      edge_d = edge_e + 1'b1;
      if (last) state_d = HOLD;
    end
    if (sample) rx_d[idx_e] = rx_bit;
    if (adv) begin
      idx_d  = idx_n;
      mosi_d = tx_e[idx_n];
    end
  end

  // state registers; a reset that interrupts a frame aborts it
  // but leaves the last received word readable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ord_q   <= MSB_FIRST;
      mode_q  <= '0;
      div_q   <= '0;
      len_q   <= '0;
      tx_q    <= '0;
      idx_q   <= '0;
      edge_q  <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      if (state_q == IDLE) data_q <= '0;
    end else begin
      state_q <= state_d;
      ord_q   <= ord_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      len_q   <= len_d;
      tx_q    <= tx_d;
      idx_q   <= idx_d;
      edge_q  <= edge_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      data_q  <= data_d;
    end
  end

  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: SPI slave model, frame timing and data.
// Directed plan frames followed by randomized frames.
module tb_spi_shift_engine;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [4:0]  length_i = '0;
  bit_order_t  bit_order_i = MSB_FIRST;
  logic        cpol_i = 1'b0;
  logic        cpha_i = 1'b0;
  logic [15:0] clk_div_i = '0;
`ifdef SPI_LOOPBACK_EN
  logic        loopback_i = 1'b0;
`endif
  logic        spi_sclk_o, spi_mosi_o;
  logic        spi_miso_i = 1'b0;
  logic [31:0] data_o;
  logic        busy_o, done_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  spi_shift_engine dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .data_i      (data_i),
    .length_i    (length_i),
    .bit_order_i (bit_order_i),
    .cpol_i      (cpol_i),
    .cpha_i      (cpha_i),
    .clk_div_i   (clk_div_i),
`ifdef SPI_LOOPBACK_EN
    .loopback_i  (loopback_i),
`endif
    .spi_sclk_o  (spi_sclk_o),
    .spi_mosi_o  (spi_mosi_o),
    .spi_miso_i  (spi_miso_i),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // i-th bit on the wire for an n-bit word
  function automatic logic wbit(input logic [31:0] v, input int n,
                                input bit lsb, input int i);
    return lsb ? v[i] : v[n-1-i];
  endfunction

  // One frame: drive the request, act as slave, check every edge
  task automatic frame(input logic [31:0] d, input int n, input bit lsb,
                       input bit pol, input bit pha, input int dv,
                       input logic [31:0] s, input bit lb,
                       input bit poke, input bit b2b);
    int p, lim, edges, mi, si;
    bit seen;
    logic prv, lv;
    logic [31:0] mask, exp;
    p     = dv + 1;
    lim   = (2 * n + 1) * p + 4;
    mask  = 32'((64'd1 << n) - 1);
    exp   = s & mask;
`ifdef SPI_LOOPBACK_EN
    loopback_i = lb;
    if (lb) exp = d & mask;
`else
    if (lb) exp = s & mask;
`endif
    data_i      = d;
    length_i    = 5'(n - 1);
    bit_order_i = lsb ? LSB_FIRST : MSB_FIRST;
    cpol_i      = pol;
    cpha_i      = pha;
    clk_div_i   = 16'(dv);
    if (!b2b) begin
      @(negedge clk);
      check("idle_sclk", spi_sclk_o, pol);
    end
    prv = spi_sclk_o;
    edges = 0; mi = 0; si = 0; seen = 0;
    if (!pha) begin
      spi_miso_i = wbit(s, n, lsb, 0);
      si = 1;
    end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_first", busy_o, 1);
    check("mosi_first", spi_mosi_o, wbit(d, n, lsb, 0));
    for (int t = 0; t < lim && !seen; t++) begin
      if (poke && t == 2) begin
        start_i = 1'b1;
        cpol_i  = ~pol;
      end
      if (poke && t == 6) begin
        start_i = 1'b0;
        cpol_i  = pol;
      end
      if (spi_sclk_o !== prv) begin
        bit lead;
        lead = (edges % 2) == 0;
        lv   = pol ^ lead;
        check("edge_count", edges < 2 * n, 1);
        check("edge_time", t, (edges + 1) * p - 1);
        check("edge_level", spi_sclk_o, lv);
        if (lead != pha) begin
          check("mosi_bit", spi_mosi_o, wbit(d, n, lsb, mi));
          mi++;
        end else if (si < n) begin
          spi_miso_i = wbit(s, n, lsb, si);
          si++;
        end
        edges++;
        prv = spi_sclk_o;
      end
      if (done_o) begin
        seen = 1;
        check("done_time", t, (2 * n + 1) * p - 1);
        check("done_edges", edges, 2 * n);
        check("done_data", data_o, exp);
        check("done_busy", busy_o, 1);
        check("final_sclk", spi_sclk_o, pol);
      end else begin
        @(negedge clk);
      end
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    check("post_busy", busy_o, 0);
    check("post_done", done_o, 0);
    check("post_mosi", spi_mosi_o, wbit(d, n, lsb, n - 1));
    check("post_data", data_o, exp);
    if (poke) begin
      repeat (3) @(negedge clk);
      check("poke_idle", busy_o, 0);
    end
    last_exp = exp;
  endtask

  initial begin
    int   edges, dones;
    logic prvs;
    repeat (3) @(negedge clk);
    check("rst_sclk", spi_sclk_o, 0);
    check("rst_mosi", spi_mosi_o, 0);
    check("rst_data", data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_i = 1'b0;

    frame(32'h0000_00A5, 8, 0, 0, 0, 0, 32'h3C, 0, 0, 0);
    frame(32'hDEAD_BEEF, 32, 1, 1, 1, 3, 32'h1234_5678, 1, 0, 0);
    frame(32'hFFFF_FFF3, 5, 0, 0, 1, 1, 32'hFFFF_FFEA, 0, 0, 0);
    check("n5_upper_zero", data_o[31:5], 0);
    frame(32'h0000_C3A9, 16, 0, 0, 0, 1, 32'h5A0F, 0, 1, 0);

    data_i      = 32'h0000_0096;
    length_i    = 5'd7;
    bit_order_i = MSB_FIRST;
    cpol_i      = 1'b0;
    cpha_i      = 1'b0;
    clk_div_i   = 16'd1;
    @(negedge clk);
    prvs    = spi_sclk_o;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    edges   = 0;
    for (int t = 0; t < 100 && edges < 7; t++) begin
      if (spi_sclk_o !== prvs) begin
        edges++;
        prvs = spi_sclk_o;
      end
      if (edges < 7) @(negedge clk);
    end
    check("abort_edge6", edges, 7);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_sclk", spi_sclk_o, 0);
    check("abort_data", data_o, last_exp);
    check("abort_done", done_o, 0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || busy_o) dones++;
    end
    check("abort_quiet", dones, 0);

    frame(32'h0000_5A3C, 14, 1, 1, 0, 0, 32'h2B71, 0, 0, 0);
    frame(32'h0000_0F0E, 14, 1, 1, 0, 0, 32'h1C4D, 0, 0, 1);

    repeat (12) begin
      logic [31:0] rd, rs;
      rd = $urandom;
      rs = $urandom;
      frame(rd, int'($urandom_range(1, 32)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), rs,
            1'($urandom_range(0, 1)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
